// File: rtl/pbch_demapper_pkg.sv
// Shared constants, FSM state type and band helper for the PBCH demapper.
// Optional DMRS passthrough is enabled in the top by PBCH_DMRS_OUT_EN.
package pbch_pkg;

   localparam int SSB_N_SC      = 240;
   localparam int SYM2_LO_END   = 47;
   localparam int SYM2_HI_START = 192;
   localparam int PBCH_N_RE     = 432;
   localparam int PBCH_N_DMRS   = 144;
   localparam int PBCH_E        = 864;

   typedef enum logic [2:0] {
      ST_NO_ID,
      ST_WAIT,
      ST_SYM1,
      ST_SYM2,
      ST_SYM3
   } pbch_state_t;

   // Symbol 2 carries PBCH only outside the SSS band.
   function automatic logic in_pbch_band(input pbch_state_t st, input logic [7:0] k);
      return (st != ST_SYM2) || (k <= 8'(SYM2_LO_END)) || (k >= 8'(SYM2_HI_START));
   endfunction

endpackage

// File: rtl/pbch_demapper_llr_fifo.sv
// Synchronous first-word-fall-through FIFO for LLR words.
// The output holds the last word read while the FIFO is empty.
module llr_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 16
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] rd_data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic [W-1:0] r_hold;
   logic         w_empty;
   logic         w_full;
   logic         w_rd;
   logic         w_wr;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_rd    = rd_en_i && !w_empty;
   // A read in the same cycle frees the slot, so a write at full is still taken.
   assign w_wr    = wr_en_i && (!w_full || w_rd);

   always_ff @(posedge clk_i) begin
      if (w_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_hold   <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_hold   <= r_mem[r_rd_ptr[AW-1:0]];
         end
      end
   end

   assign rd_data_o = w_empty ? r_hold : r_mem[r_rd_ptr[AW-1:0]];
   assign full_o    = w_full;
   assign empty_o   = w_empty;

endmodule

// File: rtl/pbch_demapper.sv
// PBCH RE demapper: strips DMRS/SSS, converts QPSK REs to saturated LLRs, AXI-stream out.
// Define PBCH_DMRS_OUT_EN to expose the raw DMRS REs on m_axis_dmrs_*.
module pbch_demapper
   import pbch_pkg::*;
#(
   parameter int IN_DW      = 32,
   parameter int LLR_DW     = 8,
   parameter int LLR_SHIFT  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [9:0]            N_id_i,
   input  logic                  N_id_valid_i,
   input  logic                  PBCH_start_i,
   input  logic [IN_DW-1:0]      s_axis_in_tdata,
   input  logic                  s_axis_in_tvalid,
   output logic [2*LLR_DW-1:0]   m_axis_llr_tdata,
   output logic                  m_axis_llr_tvalid,
   input  logic                  m_axis_llr_tready,
   output logic                  m_axis_llr_tlast,
`ifdef PBCH_DMRS_OUT_EN
   output logic [IN_DW-1:0]      m_axis_dmrs_tdata,
   output logic                  m_axis_dmrs_tvalid,
   output logic                  m_axis_dmrs_tlast,
`endif
   output logic                  busy_o,
   output logic                  aborted_o,
   output logic                  overflow_o
);

   localparam int HW = IN_DW / 2;
   localparam int FW = 2 * LLR_DW + 1;
   localparam logic signed [HW-1:0] LLR_MAX = HW'(2 ** (LLR_DW - 1) - 1);
   localparam logic signed [HW-1:0] LLR_MIN = -LLR_MAX;

   function automatic logic [LLR_DW-1:0] f_llr(input logic signed [HW-1:0] x);
      logic signed [HW-1:0] y;
      y = x >>> LLR_SHIFT;
      if (y > LLR_MAX) begin
         return LLR_MAX[LLR_DW-1:0];
      end else if (y < LLR_MIN) begin
         return LLR_MIN[LLR_DW-1:0];
      end
      return y[LLR_DW-1:0];
   endfunction

   pbch_state_t        r_state, w_state_next, w_sym;
   logic [7:0]         r_k, w_k, w_k_next;
   logic [8:0]         r_cnt, w_cnt, w_cnt_next;
   logic [1:0]         r_v, r_v_act, w_v_now, w_v_eff;
   logic               w_in_blk, w_start, w_proc, w_band, w_dmrs_pos;
   logic               w_data, w_dmrs, w_last;
   logic               r_aborted, r_overflow;
   logic               r_s1_valid, r_s1_last;
   logic [2*LLR_DW-1:0] r_s1_llr;
   logic [FW-1:0]      w_fifo_dout;
   logic               w_full, w_empty;
   logic               w_unused_nid;

   assign w_unused_nid = ^N_id_i[9:2];

   // A start pulse redefines this very cycle as SYM1 k=0 with a freshly sampled v.
   always_comb begin
      w_in_blk   = (r_state == ST_SYM1) || (r_state == ST_SYM2) || (r_state == ST_SYM3);
      w_start    = PBCH_start_i && (r_state != ST_NO_ID);
      w_v_now    = N_id_valid_i ? N_id_i[1:0] : r_v;
      w_sym      = r_state;
      w_k        = r_k;
      w_v_eff    = r_v_act;
      w_cnt      = r_cnt;
      if (w_start) begin
         w_sym   = ST_SYM1;
         w_k     = 8'd0;
         w_v_eff = w_v_now;
         w_cnt   = 9'd0;
      end
      w_proc     = s_axis_in_tvalid &&
                   ((w_sym == ST_SYM1) || (w_sym == ST_SYM2) || (w_sym == ST_SYM3));
      w_band     = in_pbch_band(w_sym, w_k);
      w_dmrs_pos = (w_k[1:0] == w_v_eff);
      w_data     = w_proc && w_band && !w_dmrs_pos;
      w_dmrs     = w_proc && w_band && w_dmrs_pos;
      w_last     = w_data && (w_cnt == 9'(PBCH_N_RE - 1));
      w_cnt_next = w_data ? w_cnt + 9'd1 : w_cnt;
      w_state_next = w_sym;
      w_k_next     = w_k;
      if (r_state == ST_NO_ID) begin
         if (N_id_valid_i) begin
            w_state_next = ST_WAIT;
         end
      end else if (w_proc) begin
         if (w_k == 8'(SSB_N_SC - 1)) begin
            w_k_next = 8'd0;
            case (w_sym)
               ST_SYM1: w_state_next = ST_SYM2;
               ST_SYM2: w_state_next = ST_SYM3;
               default: w_state_next = ST_WAIT;
            endcase
         end else begin
            w_k_next = w_k + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= ST_NO_ID;
         r_k        <= '0;
         r_cnt      <= '0;
         r_v        <= '0;
         r_v_act    <= '0;
         r_aborted  <= 1'b0;
         r_overflow <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_llr   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_k        <= w_k_next;
         r_cnt      <= w_cnt_next;
         r_v_act    <= w_v_eff;
         r_aborted  <= w_start && w_in_blk;
         r_s1_valid <= w_data;
         r_s1_last  <= w_last;
         r_s1_llr   <= {f_llr(s_axis_in_tdata[IN_DW-1:HW]), f_llr(s_axis_in_tdata[HW-1:0])};
         if (N_id_valid_i) begin
            r_v <= N_id_i[1:0];
         end
         // When full, a read this cycle is exactly what makes room for the write.
         if (r_s1_valid && w_full && !m_axis_llr_tready) begin
            r_overflow <= 1'b1;
         end
      end
   end

   llr_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .wr_en_i   (r_s1_valid),
      .wr_data_i ({r_s1_last, r_s1_llr}),
      .rd_en_i   (m_axis_llr_tready),
      .rd_data_o (w_fifo_dout),
      .full_o    (w_full),
      .empty_o   (w_empty)
   );

   assign m_axis_llr_tvalid = !w_empty;
   assign m_axis_llr_tdata  = w_fifo_dout[2*LLR_DW-1:0];
   assign m_axis_llr_tlast  = w_fifo_dout[FW-1] && !w_empty;
   assign busy_o            = w_in_blk;
   assign aborted_o         = r_aborted;
   assign overflow_o        = r_overflow;

`ifdef PBCH_DMRS_OUT_EN
   logic [7:0]       r_dcnt, w_dcnt;
   logic             r_s1_dmrs_valid, r_s1_dmrs_last;
   logic [IN_DW-1:0] r_s1_dmrs_data;
   logic             r_dmrs_tvalid, r_dmrs_tlast;
   logic [IN_DW-1:0] r_dmrs_tdata;

   assign w_dcnt = w_start ? 8'd0 : r_dcnt;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_dcnt          <= '0;
         r_s1_dmrs_valid <= 1'b0;
         r_s1_dmrs_last  <= 1'b0;
         r_s1_dmrs_data  <= '0;
         r_dmrs_tvalid   <= 1'b0;
         r_dmrs_tlast    <= 1'b0;
         r_dmrs_tdata    <= '0;
      end else begin
         r_dcnt          <= w_dmrs ? w_dcnt + 8'd1 : w_dcnt;
         r_s1_dmrs_valid <= w_dmrs;
         r_s1_dmrs_last  <= w_dmrs && (w_dcnt == 8'(PBCH_N_DMRS - 1));
         r_s1_dmrs_data  <= s_axis_in_tdata;
         r_dmrs_tvalid   <= r_s1_dmrs_valid;
         r_dmrs_tlast    <= r_s1_dmrs_valid && r_s1_dmrs_last;
         if (r_s1_dmrs_valid) begin
            r_dmrs_tdata <= r_s1_dmrs_data;
         end
      end
   end

   assign m_axis_dmrs_tdata  = r_dmrs_tdata;
   assign m_axis_dmrs_tvalid = r_dmrs_tvalid;
   assign m_axis_dmrs_tlast  = r_dmrs_tlast;
`else
   logic w_unused_dmrs;
   assign w_unused_dmrs = w_dmrs;
`endif

endmodule

// File: tb/tb_pbch_demapper.sv
// Self-checking bench for pbch_demapper: LLR table, scoreboard over whole blocks,
// overflow, abort/restart, pre-ID start, and random gaps with random backpressure.
module tb_pbch_demapper;

   localparam int IN_DW      = 32;
   localparam int LLR_DW     = 8;
   localparam int LLR_SHIFT  = 8;
   localparam int FIFO_DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic [9:0]  N_id_i = '0;
   logic        N_id_valid_i = 1'b0;
   logic        PBCH_start_i = 1'b0;
   logic [31:0] s_axis_in_tdata = '0;
   logic        s_axis_in_tvalid = 1'b0;
   logic [15:0] m_axis_llr_tdata;
   logic        m_axis_llr_tvalid;
   logic        m_axis_llr_tready = 1'b1;
   logic        m_axis_llr_tlast;
   logic        busy_o, aborted_o, overflow_o;
`ifdef PBCH_DMRS_OUT_EN
   logic [31:0] dmrs_tdata;
   logic        dmrs_tvalid, dmrs_tlast;
`endif

   always #5 clk = ~clk;

   pbch_demapper #(
      .IN_DW(IN_DW), .LLR_DW(LLR_DW), .LLR_SHIFT(LLR_SHIFT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk_i             (clk),
      .reset_i           (reset_i),
      .N_id_i            (N_id_i),
      .N_id_valid_i      (N_id_valid_i),
      .PBCH_start_i      (PBCH_start_i),
      .s_axis_in_tdata   (s_axis_in_tdata),
      .s_axis_in_tvalid  (s_axis_in_tvalid),
      .m_axis_llr_tdata  (m_axis_llr_tdata),
      .m_axis_llr_tvalid (m_axis_llr_tvalid),
      .m_axis_llr_tready (m_axis_llr_tready),
      .m_axis_llr_tlast  (m_axis_llr_tlast),
`ifdef PBCH_DMRS_OUT_EN
      .m_axis_dmrs_tdata (dmrs_tdata),
      .m_axis_dmrs_tvalid(dmrs_tvalid),
      .m_axis_dmrs_tlast (dmrs_tlast),
`endif
      .busy_o            (busy_o),
      .aborted_o         (aborted_o),
      .overflow_o        (overflow_o)
   );

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
      logic [15:0] exp;   // {llr_b1, llr_b0}
   } llr_vec_t;

   llr_vec_t    tab[8];
   logic [16:0] q[$];
   logic [16:0] mon_exp;
   int  n_checks = 0, n_errors = 0;
   int  n_out = 0, n_last = 0, n_abort = 0;
   bit  busy_seen = 0;
   bit  rnd_mode = 0, ready_cmd = 1;
   // reference model state
   bit  m_have_id = 0, m_act = 0, m_cap = 0;
   int  m_v = 0, m_vact = 0, m_sym = 0, m_k = 0, m_cnt = 0, m_dcnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_data(input int sym, input int k, input int v);
      return ((k % 4) != v) && (sym != 1 || k <= 47 || k >= 192);
   endfunction

   function automatic logic [7:0] m_llr(input logic [15:0] x);
      int y;
      y = int'($signed(x));
      y = y >>> LLR_SHIFT;
      if (y > 127) y = 127;
      if (y < -127) y = -127;
      return 8'(y);
   endfunction

   function automatic logic [15:0] enc_re(input int idx);
      return 16'(((idx % 240) - 120) * 256);
   endfunction

   function automatic logic [15:0] enc_im(input int idx);
      return 16'(((idx / 240) * 40 - 40) * 256);
   endfunction

   // Drives one cycle of input; the model pushes the expected word for each data RE.
   task automatic drive(input bit st, input bit vl, input logic [15:0] re, input logic [15:0] im,
                        input bit use_exp, input logic [15:0] exp);
      logic [15:0] w;
      if (st && m_have_id) begin
         m_act = 1; m_sym = 0; m_k = 0; m_cnt = 0; m_vact = m_v;
      end
      if (vl && m_act) begin
         if (is_data(m_sym, m_k, m_vact)) begin
            w = use_exp ? exp : {m_llr(im), m_llr(re)};
            if (!(m_cap && q.size() >= FIFO_DEPTH))
               q.push_back({1'(m_cnt == 431), w});
            m_cnt++;
            m_dcnt++;
         end
         if (m_k == 239) begin
            m_k = 0;
            if (m_sym == 2) m_act = 0;
            else m_sym++;
         end else begin
            m_k++;
         end
      end
      PBCH_start_i     = st;
      s_axis_in_tvalid = vl;
      s_axis_in_tdata  = {im, re};
      @(posedge clk); #1;
      PBCH_start_i     = 0;
      s_axis_in_tvalid = 0;
   endtask

   task automatic idle();
      drive(0, 0, 16'h0, 16'h0, 0, 16'h0);
   endtask

   task automatic set_nid(input int n);
      N_id_i       = 10'(n);
      N_id_valid_i = 1;
      @(posedge clk); #1;
      N_id_valid_i = 0;
      m_v          = n % 4;
      m_have_id    = 1;
   endtask

   // st_mode: 0 none, 1 start with idx 0, 2 start on an idle cycle before idx 0
   task automatic run_range(input int first, input int last_i, input int gap_pct,
                            input int st_mode, input bit rnd_data);
      for (int i = first; i <= last_i; i++) begin
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle();
         if (i == 0 && st_mode == 2) drive(1, 0, 16'h0, 16'h0, 0, 16'h0);
         if (rnd_data)
            drive(i == 0 && st_mode == 1, 1, 16'($urandom), 16'($urandom), 0, 16'h0);
         else
            drive(i == 0 && st_mode == 1, 1, enc_re(i), enc_im(i), 0, 16'h0);
      end
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while (q.size() != 0 && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (5) @(posedge clk);
      #1;
      check({name, "_drained"}, q.size(), 0);
   endtask

   initial begin
      forever begin
         @(posedge clk); #2;
         m_axis_llr_tready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_cmd;
      end
   end

   always @(negedge clk) begin
      if (busy_o) busy_seen = 1;
      if (aborted_o) n_abort++;
      if (m_axis_llr_tvalid && m_axis_llr_tready) begin
         n_out++;
         if (m_axis_llr_tlast) n_last++;
         if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_out: got %0h expected none", {m_axis_llr_tlast, m_axis_llr_tdata});
         end else begin
            mon_exp = q.pop_front();
            check("llr_word", {15'd0, m_axis_llr_tlast, m_axis_llr_tdata}, {15'd0, mon_exp});
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int o0, l0, a0, j;
      bit pend, done17;
      tab[0] = '{16'h7FFF, 16'h8000, 16'h817F};
      tab[1] = '{16'h0100, 16'hFF00, 16'hFF01};
      tab[2] = '{16'h0000, 16'hFFFF, 16'hFF00};
      tab[3] = '{16'h00FF, 16'hFF01, 16'hFF00};
      tab[4] = '{16'h7F00, 16'h8100, 16'h817F};
      tab[5] = '{16'h80FF, 16'h7EFF, 16'h7E81};
      tab[6] = '{16'h03E8, 16'hFC18, 16'hFC03};
      tab[7] = '{16'hFF00, 16'h01FF, 16'h01FF};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      reset_i = 0;
      check("rst_tvalid", m_axis_llr_tvalid, 0);
      check("rst_tdata", m_axis_llr_tdata, 0);
      check("rst_tlast", m_axis_llr_tlast, 0);
      check("rst_busy", busy_o, 0);
      check("rst_aborted", aborted_o, 0);
      check("rst_overflow", overflow_o, 0);
      $display("step reset: checks=%0d", n_checks);

      // start before any cell ID is ignored
      busy_seen = 0;
      o0 = n_out;
      run_range(0, 239, 0, 1, 0);
      repeat (10) idle();
      check("noid_outputs", n_out - o0, 0);
      check("noid_busy", busy_seen, 0);
      set_nid(2);
      o0 = n_out; l0 = n_last;
      run_range(0, 719, 0, 1, 0);
      wait_drain("nid2");
      check("nid2_count", n_out - o0, 432);
      check("nid2_tlast", n_last - l0, 1);
      $display("step nid2 block: outputs=%0d", n_out - o0);

      // N_id=5: latency, busy timing, full block
      set_nid(5);
      o0 = n_out; l0 = n_last;
      drive(1, 1, enc_re(0), enc_im(0), 0, 16'h0);
      check("lat_cycle1_tvalid", m_axis_llr_tvalid, 0);
      check("lat_busy", busy_o, 1);
      idle();
      check("lat_cycle2_tvalid", m_axis_llr_tvalid, 1);
      run_range(1, 718, 0, 0, 0);
      check("busy_before_last", busy_o, 1);
      drive(0, 1, enc_re(719), enc_im(719), 0, 16'h0);
      check("busy_after_last", busy_o, 0);
      wait_drain("nid5");
      check("nid5_count", n_out - o0, 432);
      check("nid5_tlast", n_last - l0, 1);
      $display("step nid5 block: outputs=%0d", n_out - o0);

      // hand-derived LLR vectors placed on the first data REs of a block
      j = 0;
      for (int i = 0; i < 720; i++) begin
         if (j < 8 && is_data(i / 240, i % 240, 1)) begin
            $display("llr vec %0d: re=%h im=%h expect=%h", j, tab[j].re, tab[j].im, tab[j].exp);
            drive(i == 0, 1, tab[j].re, tab[j].im, 1, tab[j].exp);
            j++;
         end else begin
            drive(i == 0, 1, enc_re(i), enc_im(i), 0, 16'h0);
         end
      end
      wait_drain("table");

      // full backpressure: 16 words held, overflow on the 17th data RE
      ready_cmd = 0;
      m_cap = 1;
      idle();
      m_dcnt = 0; pend = 0; done17 = 0;
      o0 = n_out;
      for (int i = 0; i < 720; i++) begin
         drive(i == 0, 1, enc_re(i), enc_im(i), 0, 16'h0);
         if (m_dcnt == 17 && !done17) begin
            check("ovf_at_17th", overflow_o, 0);
            done17 = 1; pend = 1;
         end else if (pend) begin
            check("ovf_after_17th", overflow_o, 1);
            pend = 0;
         end
      end
      repeat (5) idle();
      check("stall_no_output", n_out - o0, 0);
      check("stall_tvalid", m_axis_llr_tvalid, 1);
      ready_cmd = 1;
      m_cap = 0;
      wait_drain("stall");
      check("stall_drain_count", n_out - o0, 16);
      check("ovf_sticky", overflow_o, 1);
      $display("step overflow: drained=%0d", n_out - o0);
      reset_i = 1;
      @(posedge clk); #1;
      reset_i = 0;
      m_act = 0; m_have_id = 0; m_v = 0;
      check("rst2_overflow", overflow_o, 0);
      check("rst2_busy", busy_o, 0);
      check("rst2_tvalid", m_axis_llr_tvalid, 0);

      // restart at SYM2 k=100 with N_id changed mid-block
      set_nid(5);
      o0 = n_out; l0 = n_last; a0 = n_abort;
      for (int i = 0; i < 340; i++) begin
         if (i == 50) set_nid(7);
         drive(i == 0, 1, enc_re(i), enc_im(i), 0, 16'h0);
      end
      run_range(0, 719, 0, 1, 0);
      wait_drain("abort");
      check("abort_pulses", n_abort - a0, 1);
      check("abort_tlast", n_last - l0, 1);
      check("abort_count", n_out - o0, 648);
      $display("step abort: outputs=%0d aborts=%0d", n_out - o0, n_abort - a0);

      // random input gaps and random backpressure
      set_nid(11);
      rnd_mode = 1;
      o0 = n_out;
      run_range(0, 719, 50, 2, 1);
      run_range(0, 719, 50, 1, 1);
      wait_drain("random");
      rnd_mode = 0;
      check("random_count", n_out - o0, 864);
      check("random_no_ovf", overflow_o, 0);
      $display("step random: outputs=%0d", n_out - o0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pbch_demapper.md
Name: pbch_demapper

Overview:
- Downstream consumer of the FFT demodulator output: takes the 240-subcarrier SSB grid of the three PBCH symbols.
- Removes DMRS resource elements (position v = N_id mod 4) and the SSS band of symbol 2.
- Converts the remaining 432 QPSK REs into 864 saturated soft bits (LLRs) for the PBCH decoder.
- Output is AXI-stream with backpressure, buffered by a small FIFO because the input cannot stall.

Parameters:
- IN_DW, 32, complex input width; real part in [IN_DW/2-1:0], imag in [IN_DW-1:IN_DW/2], both signed.
- LLR_DW, 8, signed width of each output LLR.
- LLR_SHIFT, 8, arithmetic right shift applied to re/im before saturation.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 4.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- N_id_i  in  10  cell ID
- N_id_valid_i  in  1  N_id_i qualifier; latched on the same cycle
- PBCH_start_i  in  1  one-cycle pulse coincident with the first valid RE (k=0) of PBCH symbol 1
- s_axis_in_tdata  in  IN_DW  FFT RE, subcarriers k=0..239 in order
- s_axis_in_tvalid  in  1  RE qualifier; no tready
- m_axis_llr_tdata  out  2*LLR_DW  {llr_b1 (imag), llr_b0 (real)}
- m_axis_llr_tvalid  out  1  output valid
- m_axis_llr_tready  in  1  downstream ready
- m_axis_llr_tlast  out  1  high on the 432nd RE of a block
- busy_o  out  1  high from PBCH_start accepted until the last RE of symbol 3 is consumed
- aborted_o  out  1  one-cycle pulse when a block is restarted mid-stream
- overflow_o  out  1  sticky; set when an RE is dropped because the FIFO is full

Behaviour:
- Reset: all outputs 0, state NO_ID, FIFO empty, v=0, counters 0.
- v register: loads N_id_i[1:0] whenever N_id_valid_i=1. The value is sampled into v_act at block start; mid-block changes do not affect the current block.
- FSM states: NO_ID, WAIT, SYM1, SYM2, SYM3.
  - NO_ID -> WAIT on first N_id_valid_i.
  - In NO_ID, PBCH_start_i is ignored.
  - WAIT -> SYM1 on PBCH_start_i. That same-cycle RE is processed as k=0 of SYM1.
- Subcarrier counter k (0..239) advances only on s_axis_in_tvalid.
  - At k=239: SYM1->SYM2, SYM2->SYM3, SYM3->WAIT.
  - busy_o drops the cycle after the SYM3 k=239 RE.
- Data RE selection:
  - SYM1/SYM3: k mod 4 != v_act, giving 180 REs each.
  - SYM2: (k<=47 or k>=192) and k mod 4 != v_act, giving 72 REs.
  - Total 432 REs per block.
- LLR for each of re and im:
  - y = x >>> LLR_SHIFT.
  - Saturate to [-(2^(LLR_DW-1)-1), +(2^(LLR_DW-1)-1)]; the most-negative code is never produced.
  - Sign convention: positive LLR means bit 0.
- Pipeline:
  - Stage 1 registers selection + LLRs + last flag.
  - Stage 2 writes the FIFO. FIFO is first-word fall-through.
  - With the FIFO empty and tready=1, tvalid appears 2 cycles after the input RE.
- Handshake:
  - Transfer occurs when tvalid && tready.
  - tdata/tlast are stable while tvalid=1 and tready=0.
- Full FIFO: a write while full drops that RE and sets overflow_o, which stays set until reset.
  - A simultaneous read and write at full is allowed; no drop.
- Empty FIFO: tvalid=0; tdata holds the last value.
- PBCH_start_i while in SYM1/2/3:
  - Pulse aborted_o.
  - Restart at SYM1 k=0 with the new RE; sample v_act anew.
  - The partial block already in the FIFO is still output, without tlast.
- s_axis_in_tvalid=0 gaps: counters hold; no output generated.
- PBCH_start_i with s_axis_in_tvalid=0 is still accepted; k=0 is the next valid RE.
- Reset mid-block: immediate return to NO_ID; FIFO flushed.

Optional Feature:
- Macro: PBCH_DMRS_OUT_EN.
- When defined, adds ports:
  - m_axis_dmrs_tdata (IN_DW)
  - m_axis_dmrs_tvalid (1)
  - m_axis_dmrs_tlast (1)
- These output the 144 raw DMRS REs (k mod 4 == v_act within PBCH regions), 2 cycles after input, with no backpressure. tlast is on the 144th.
- When not defined, the ports are absent and DMRS REs are simply discarded.

Decomposition:
- Package pbch_pkg holds:
  - SSB_N_SC=240, SYM2_LO_END=47, SYM2_HI_START=192
  - PBCH_N_RE=432, PBCH_N_DMRS=144, PBCH_E=864
  - State enum pbch_state_t
- One sub-module: llr_fifo, a synchronous FWFT FIFO (width 2*LLR_DW+1, depth FIFO_DEPTH) with full/empty flags.

Test Plan:
- N_id=5 (v=1), one block, tready=1: 432 outputs; tlast only on the 432nd; no output for k=1,5,9,... or SYM2 k=48..191.
- re=+32767, im=-32768, LLR_SHIFT=8, LLR_DW=8: output {-127, +127}. re=256, im=-256: output {-1, +1}.
- tready=0 throughout one block, FIFO_DEPTH=16: exactly 16 entries held; overflow_o=1 after the 17th data RE; later drain yields 16 words.
- PBCH_start_i at SYM2 k=100: aborted_o pulses once; the next 432 data REs end with a single tlast; v_act re-sampled.
- PBCH_start_i before any N_id_valid_i: no outputs, busy_o stays 0. Then N_id=2 and a start: DMRS skipped at k mod 4 == 2.
- Random tvalid gaps (50%) and random tready: output sequence matches the reference model bit-exactly; no overflow with FIFO_DEPTH=16.
